// File: rtl/data_mem_unit.sv
// Data-memory stage between EX and WB: byte/half/word loads and stores with a
// configurable access latency, plus registered branch decision. Optional macro: DMEM_CLEAR_ON_RESET_EN.
module data_mem_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [DATA_W-1:0] write_data,
    input  logic              branch,
    input  logic              zero,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [DATA_W-1:0] read_data,
    output logic              rdata_valid,
    output logic              stall,
    output logic              access_err,
    output logic              pc_src,
    output logic [ADDR_W-1:0] branch_addr
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int LANES = DATA_W / 8;
    localparam int CNT_W = 4;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               op_write_reg;
    logic [1:0]         size_reg;
    logic               unsigned_reg;
    logic [IDX_W-1:0]   index_reg;
    logic [1:0]         offset_reg;
    logic [DATA_W-1:0]  data_reg;

    logic               req;
    logic               req_bad;
    logic               commit;
    logic [LANES-1:0]   lane_we;
    logic [7:0]         lane_wdata [LANES];
    logic [7:0]         lane_rdata [LANES];
    logic [DATA_W-1:0]  rd_word;
    logic [DATA_W-1:0]  load_ext;
    logic               unused_addr_bits;

    // Upper address bits are deliberately ignored so accesses wrap modulo DEPTH*4.
    assign unused_addr_bits = ^alu_result[ADDR_W-1:IDX_W+2];

    assign req     = mem_read | mem_write;
    assign req_bad = (mem_read & mem_write)
                   | (mem_size == SIZE_RSVD)
                   | ((mem_size == SIZE_HALF) & alu_result[0])
                   | ((mem_size == SIZE_WORD) & (alu_result[1:0] != 2'b00));

    assign commit = (state_reg == BUSY) && (cnt_reg == '0);

    // Per-lane write enable and data; the memory is split into byte-wide banks.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_comb begin
                lane_we[gi]    = 1'b0;
                lane_wdata[gi] = data_reg[7:0];
                if (commit && op_write_reg) begin
                    case (size_reg)
                        SIZE_BYTE: lane_we[gi] = (offset_reg == 2'(gi));
                        SIZE_HALF: lane_we[gi] = (offset_reg[1] == ((gi / 2) == 1));
                        SIZE_WORD: lane_we[gi] = 1'b1;
                        default:   lane_we[gi] = 1'b0;
                    endcase
                end
                case (size_reg)
                    SIZE_HALF: lane_wdata[gi] = data_reg[8*(gi%2) +: 8];
                    SIZE_WORD: lane_wdata[gi] = data_reg[8*gi +: 8];
                    default:   lane_wdata[gi] = data_reg[7:0];
                endcase
            end

`ifdef DMEM_CLEAR_ON_RESET_EN
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        lane_mem[i] <= 8'h00;
                    end
                end else if (lane_we[gi]) begin
                    lane_mem[index_reg] <= lane_wdata[gi];
                end
            end
`else
            always_ff @(posedge clk) begin
                if (lane_we[gi]) begin
                    lane_mem[index_reg] <= lane_wdata[gi];
                end
            end
`endif

            assign lane_rdata[gi] = lane_mem[index_reg];
        end
    endgenerate

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < LANES; i++) begin
            rd_word[8*i +: 8] = lane_rdata[i];
        end
    end

    // Little-endian lane extraction followed by sign/zero extension.
    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b        = rd_word[8*offset_reg +: 8];
        h        = offset_reg[1] ? rd_word[31:16] : rd_word[15:0];
        load_ext = rd_word;
        case (size_reg)
            SIZE_BYTE: load_ext = unsigned_reg ? {{(DATA_W-8){1'b0}}, b}
                                               : {{(DATA_W-8){b[7]}}, b};
            SIZE_HALF: load_ext = unsigned_reg ? {{(DATA_W-16){1'b0}}, h}
                                               : {{(DATA_W-16){h[15]}}, h};
            default:   load_ext = rd_word;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            op_write_reg <= 1'b0;
            size_reg     <= SIZE_BYTE;
            unsigned_reg <= 1'b0;
            index_reg    <= '0;
            offset_reg   <= 2'b00;
            data_reg     <= '0;
            read_data    <= '0;
            rdata_valid  <= 1'b0;
            stall        <= 1'b0;
            access_err   <= 1'b0;
            pc_src       <= 1'b0;
            branch_addr  <= '0;
        end else begin
            pc_src      <= branch & zero;
            branch_addr <= branch_target;
            rdata_valid <= 1'b0;
            access_err  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        if (req_bad) begin
                            access_err <= 1'b1;
                        end else begin
                            op_write_reg <= mem_write;
                            size_reg     <= mem_size;
                            unsigned_reg <= mem_unsigned;
                            index_reg    <= alu_result[IDX_W+1:2];
                            offset_reg   <= alu_result[1:0];
                            data_reg     <= write_data;
                            cnt_reg      <= CNT_W'(LATENCY - 1);
                            stall        <= 1'b1;
                            state_reg    <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_reg == '0) begin
                        stall     <= 1'b0;
                        state_reg <= DONE;
                        if (!op_write_reg) begin
                            read_data   <= load_ext;
                            rdata_valid <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    stall     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
Parametrised data-memory stage for the MIPS pipeline, between EX and WB. Supports byte/half/word loads and stores with sign/zero extension and a configurable access latency. A stall output freezes the pipeline while an access is in flight. Also registers the branch decision (pc_src) and branch target for the fetch stage.

Parameters:
DATA_W, 32, data word width in bits; fixed at 32 for byte-lane logic
ADDR_W, 32, byte-address width
DEPTH, 256, memory depth in words; power of two, >= 4
LATENCY, 1, cycles from request acceptance to completion; legal range 1..15

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-high reset
mem_read  in  1  load request
mem_write  in  1  store request
mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved
mem_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend
alu_result  in  ADDR_W  byte address of the access
write_data  in  DATA_W  store data; low bits used for byte/half
branch  in  1  branch instruction in this stage
zero  in  1  ALU zero flag
branch_target  in  ADDR_W  computed branch address
read_data  out  DATA_W  extended load result
rdata_valid  out  1  one-cycle pulse when read_data is updated
stall  out  1  access in flight; pipeline must hold
access_err  out  1  one-cycle pulse on a rejected request
pc_src  out  1  registered branch & zero
branch_addr  out  ADDR_W  registered branch_target

Behaviour:
- Reset (async, active-high): state IDLE, counter 0; read_data, rdata_valid, stall, access_err, pc_src, branch_addr all 0. In-flight access aborted; a pending store is not written.
- Every cycle, not reset: pc_src <= branch & zero; branch_addr <= branch_target. Independent of FSM state and stall.
- Word index = alu_result[log2(DEPTH)+1:2]. Upper address bits ignored, so addresses wrap modulo DEPTH*4. Byte lanes are little-endian: offset 0 = bits 7:0.
- Request = mem_read | mem_write, sampled only in IDLE.
- Rejected in IDLE, with access_err pulsed next cycle, no state change and memory untouched, if any of:
  - mem_read & mem_write both set
  - mem_size = 11
  - half access with alu_result[0] = 1
  - word access with alu_result[1:0] != 00
- FSM states:
  - IDLE: on an accepted request, latch op, size, unsigned, index, offset and data; counter <= LATENCY-1; go BUSY; stall = 1 from the next cycle.
  - BUSY: hold; stall = 1; all inputs ignored. When counter = 0, perform the access and go DONE; otherwise decrement the counter.
  - DONE: stall = 0 for one cycle, so the pipeline advances. A new request is not accepted here. Always return to IDLE.
- Store at completion: write only the addressed lanes. Byte uses write_data[7:0]; half uses write_data[15:0]; word writes all 4 lanes. Other lanes keep their contents.
- Load at completion: read_data <= extracted byte/half/word, sign- or zero-extended per the latched mem_unsigned; rdata_valid = 1 for exactly that cycle. read_data holds until the next load.
- Store completion does not change read_data or rdata_valid.
- Request-to-result latency = LATENCY+1 edges. stall is high for LATENCY cycles per access.
- No forwarding. A load issued immediately after a store to the same address sees the new data, because accesses are serialised.

Optional Feature:
DMEM_CLEAR_ON_RESET_EN
- Defined: assertion of reset also clears every memory word to 0. Loads after reset return 0 until written.
- Not defined: memory array has no reset; contents are undefined at power-up and retained across reset. Only control and output registers reset.

Test Plan:
- LATENCY=1; sw 0xDEADBEEF @0x10, then lw @0x10 -> stall high 1 cycle per access; read_data=0xDEADBEEF with rdata_valid pulse 2 edges after lw acceptance.
- After the above: sb 0x55 @0x11; lbu @0x11 -> 0x00000055; lw @0x10 -> 0xDEAD55EF; lb @0x13 -> 0xFFFFFFDE; lhu @0x12 -> 0x0000DEAD.
- lw @0x12; sh @0x13; mem_size=11; mem_read & mem_write together -> each gives one access_err pulse, stall stays 0, memory and read_data unchanged.
- LATENCY=4; lw issued, input address changed during BUSY -> stall high exactly 4 cycles; result comes from the originally latched address.
- DEPTH=256; sw 0x12345678 @0x400, then lw @0x0 -> 0x12345678 (wrap); branch=1, zero=1, branch_target=0x40 -> next cycle pc_src=1, branch_addr=0x40; zero=0 -> pc_src=0.
- Assert reset during BUSY of a pending sw -> outputs 0 immediately, state IDLE. The store is not committed: verify by reading back old data without the macro, and 0 with DMEM_CLEAR_ON_RESET_EN.
